// File: rtl/pattern_gen_pkg.sv
// Shared constants for the test-pattern generator: mode codes, colour codes,
// LFSR taps and helpers that widen colours to the configured channel width.
package pattern_pkg;

    localparam logic [2:0] MODE_BAR     = 3'd0;
    localparam logic [2:0] MODE_GRID    = 3'd1;
    localparam logic [2:0] MODE_GRAY    = 3'd2;
    localparam logic [2:0] MODE_COLOR   = 3'd3;
    localparam logic [2:0] MODE_CHECKER = 3'd4;
    localparam logic [2:0] MODE_SCROLL  = 3'd5;
    localparam logic [2:0] MODE_NOISE   = 3'd6;
    localparam logic [2:0] MODE_BLACK   = 3'd7;

    // Colours are {R,G,B} on/off codes; rgb_expand turns them into full-scale channels.
    localparam logic [2:0] RGB_BLACK   = 3'b000;
    localparam logic [2:0] RGB_BLUE    = 3'b001;
    localparam logic [2:0] RGB_GREEN   = 3'b010;
    localparam logic [2:0] RGB_CYAN    = 3'b011;
    localparam logic [2:0] RGB_RED     = 3'b100;
    localparam logic [2:0] RGB_MAGENTA = 3'b101;
    localparam logic [2:0] RGB_YELLOW  = 3'b110;
    localparam logic [2:0] RGB_WHITE   = 3'b111;

    localparam logic [23:0] LFSR_TAPS  = 24'hE1_0000;
    localparam int          MAX_DATA_W = 16;

    function automatic logic [3*MAX_DATA_W-1:0] rgb_expand(input logic [2:0] rgb, input int data_w);
        logic [3*MAX_DATA_W-1:0] ch;
        logic [3*MAX_DATA_W-1:0] res;
        ch                   = '0;
        ch[MAX_DATA_W-1:0]   = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - data_w);
        res                  = '0;
        if (rgb[0]) res = res | ch;
        if (rgb[1]) res = res | (ch << data_w);
        if (rgb[2]) res = res | (ch << (2 * data_w));
        return res;
    endfunction

    // Places an 8-bit value at the top of a data_w-bit channel.
    function automatic logic [MAX_DATA_W-1:0] byte_align(input logic [7:0] b, input int data_w);
        logic [MAX_DATA_W-1:0] wide;
        wide = {{(MAX_DATA_W-8){1'b0}}, b};
        return (data_w >= 8) ? (wide << (data_w - 8)) : (wide >> (8 - data_w));
    endfunction

    function automatic logic [2:0] bar_rgb(input logic [2:0] seg);
        logic [2:0] res;
        case (seg)
            3'd0:    res = RGB_WHITE;
            3'd1:    res = RGB_YELLOW;
            3'd2:    res = RGB_CYAN;
            3'd3:    res = RGB_GREEN;
            3'd4:    res = RGB_MAGENTA;
            3'd5:    res = RGB_RED;
            3'd6:    res = RGB_BLACK;
            3'd7:    res = RGB_BLUE;
            default: res = RGB_BLACK;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Pixel request/response channel between a display driver (master) and pattern_gen (slave).
interface pattern_gen_if #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 12
) ();
    logic                  req;
    logic [COORD_W-1:0]    pixel_hpos;
    logic [COORD_W-1:0]    pixel_vpos;
    logic                  valid;
    logic [3*DATA_W-1:0]   data;
    logic                  frame_start;

    modport master (output req, pixel_hpos, pixel_vpos, input valid, data, frame_start);
    modport slave  (input req, pixel_hpos, pixel_vpos, output valid, data, frame_start);
endinterface

// File: rtl/pattern_gen_lfsr.sv
// 24-bit right-shifting Galois LFSR; exposes the current state and steps when enabled.
module pattern_lfsr
    import pattern_pkg::*;
#(
    parameter logic [23:0] SEED = 24'hACE1_5A
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_en,
    output logic [23:0] o_state
);

    logic [23:0] r_state;

    // State register; only reseeded by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {1'b0, r_state[23:1]} ^ (r_state[0] ? LFSR_TAPS : 24'h00_0000);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/pattern_gen.sv
// Two-stage pipelined test-pattern source: stage 1 resolves per-pixel pattern
// features, stage 2 muxes the final colour. Frame settings latch on a (0,0) request.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int          DATA_W      = 8,
    parameter int          COORD_W     = 12,
    parameter int          GRID_SHIFT  = 5,
    parameter int          SCROLL_STEP = 4,
    parameter logic [23:0] LFSR_SEED   = 24'hACE1_5A
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [2:0]           i_mode,
    input  logic [3*DATA_W-1:0]  i_color,
    input  logic [COORD_W-1:0]   i_h_res,
    input  logic [COORD_W-1:0]   i_v_res,
    pattern_gen_if.slave         pix
);

    localparam logic [COORD_W:0] L_STEP  = (COORD_W+1)'(SCROLL_STEP);
    localparam logic [COORD_W:0] L_PITCH = (COORD_W+1)'(2 ** GRID_SHIFT);

    // Frame-level state
    logic [2:0]           r_mode_q;
    logic [COORD_W-1:0]   r_hres_q;
    logic [COORD_W-1:0]   r_vres_q;
    logic [COORD_W-1:0]   r_bar_w;
    logic [COORD_W-1:0]   r_scroll_off;
    logic [2:0]           r_seg;
    logic [COORD_W-1:0]   r_bound;

    // Stage 1
    logic                 r_s1_vld;
    logic                 r_s1_fs;
    logic                 r_s1_oor;
    logic                 r_s1_barz;
    logic                 r_s1_grid;
    logic                 r_s1_check;
    logic                 r_s1_scroll;
    logic [2:0]           r_s1_mode;
    logic [2:0]           r_s1_seg;
    logic [DATA_W-1:0]    r_s1_gray;
    logic [23:0]          r_s1_lfsr;

    // Stage 2
    logic                 r_valid;
    logic                 r_frame_start;
    logic [3*DATA_W-1:0]  r_data;

    logic                 w_fs;
    logic [2:0]           w_mode;
    logic [COORD_W-1:0]   w_hres;
    logic [COORD_W-1:0]   w_vres;
    logic [COORD_W-1:0]   w_bar_w;
    logic [COORD_W:0]     w_scroll_sum;
    logic [COORD_W-1:0]   w_scroll_nx;
    logic [COORD_W-1:0]   w_scroll;
    logic [COORD_W:0]     w_dist;
    logic                 w_scroll_hit;
    logic                 w_oor;
    logic [2:0]           w_seg;
    logic [COORD_W-1:0]   w_bound;
    logic [23:0]          w_lfsr;
    logic [3*DATA_W-1:0]  w_color;

    function automatic logic [3*DATA_W-1:0] rgb_full(input logic [2:0] rgb);
        return (3*DATA_W)'(rgb_expand(rgb, DATA_W));
    endfunction

    pattern_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (pix.req),
        .o_state (w_lfsr)
    );

    // Effective frame settings: a (0,0) request already sees the values it latches.
    always_comb begin
        w_fs         = pix.req && (pix.pixel_hpos == '0) && (pix.pixel_vpos == '0);
        w_scroll_sum = {1'b0, r_scroll_off} + L_STEP;
        w_scroll_nx  = (w_scroll_sum >= {1'b0, i_h_res}) ? COORD_W'(w_scroll_sum - {1'b0, i_h_res})
                                                         : COORD_W'(w_scroll_sum);
        if (w_fs) begin
            w_mode   = i_mode;
            w_hres   = i_h_res;
            w_vres   = i_v_res;
            w_bar_w  = i_h_res >> 3;
            w_scroll = w_scroll_nx;
        end else begin
            w_mode   = r_mode_q;
            w_hres   = r_hres_q;
            w_vres   = r_vres_q;
            w_bar_w  = r_bar_w;
            w_scroll = r_scroll_off;
        end
    end

    // Per-pixel features: range check, scroll distance and the running bar segment.
    always_comb begin
        w_oor = (pix.pixel_hpos >= w_hres) || (pix.pixel_vpos >= w_vres);
        if ({1'b0, pix.pixel_hpos} >= {1'b0, w_scroll}) begin
            w_dist = {1'b0, pix.pixel_hpos} - {1'b0, w_scroll};
        end else begin
            w_dist = {1'b0, pix.pixel_hpos} + {1'b0, w_hres} - {1'b0, w_scroll};
        end
        w_scroll_hit = (w_dist < L_PITCH);
        if (pix.pixel_hpos == '0) begin
            w_seg   = 3'd0;
            w_bound = w_bar_w;
        end else if ((pix.pixel_hpos == r_bound) && (r_seg != 3'd7)) begin
            w_seg   = r_seg + 3'd1;
            w_bound = r_bound + w_bar_w;
        end else begin
            w_seg   = r_seg;
            w_bound = r_bound;
        end
    end

    // Frame-level state updates on accepted requests.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode_q     <= MODE_BAR;
            r_hres_q     <= '0;
            r_vres_q     <= '0;
            r_bar_w      <= '0;
            r_scroll_off <= '0;
            r_seg        <= 3'd0;
            r_bound      <= '0;
        end else if (pix.req) begin
            r_seg   <= w_seg;
            r_bound <= w_bound;
            if (w_fs) begin
                r_mode_q     <= w_mode;
                r_hres_q     <= w_hres;
                r_vres_q     <= w_vres;
                r_bar_w      <= w_bar_w;
                r_scroll_off <= w_scroll;
            end
        end
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vld    <= 1'b0;
            r_s1_fs     <= 1'b0;
            r_s1_oor    <= 1'b0;
            r_s1_barz   <= 1'b0;
            r_s1_grid   <= 1'b0;
            r_s1_check  <= 1'b0;
            r_s1_scroll <= 1'b0;
            r_s1_mode   <= MODE_BAR;
            r_s1_seg    <= 3'd0;
            r_s1_gray   <= '0;
            r_s1_lfsr   <= LFSR_SEED;
        end else begin
            r_s1_vld <= pix.req;
            r_s1_fs  <= w_fs;
            if (pix.req) begin
                r_s1_oor    <= w_oor;
                r_s1_barz   <= (w_bar_w == '0);
                r_s1_grid   <= (pix.pixel_hpos[GRID_SHIFT-1:0] == '0) || (pix.pixel_vpos[GRID_SHIFT-1:0] == '0);
                r_s1_check  <= pix.pixel_hpos[GRID_SHIFT] ^ pix.pixel_vpos[GRID_SHIFT];
                r_s1_scroll <= w_scroll_hit;
                r_s1_mode   <= w_mode;
                r_s1_seg    <= w_seg;
                r_s1_gray   <= pix.pixel_hpos[DATA_W-1:0];
                r_s1_lfsr   <= w_lfsr;
            end
        end
    end

    // Colour mux for the pixel held in stage 1.
    always_comb begin
        w_color = '0;
        if (r_s1_oor) begin
            w_color = rgb_full(RGB_BLACK);
        end else begin
            case (r_s1_mode)
                MODE_BAR:     w_color = rgb_full(r_s1_barz ? RGB_WHITE : bar_rgb(r_s1_seg));
                MODE_GRID:    w_color = rgb_full(r_s1_grid ? RGB_RED : RGB_BLACK);
                MODE_GRAY:    w_color = {3{r_s1_gray}};
                MODE_COLOR:   w_color = i_color;
                MODE_CHECKER: w_color = rgb_full(r_s1_check ? RGB_WHITE : RGB_BLACK);
                MODE_SCROLL:  w_color = rgb_full(r_s1_scroll ? RGB_WHITE : RGB_BLACK);
                MODE_NOISE:   w_color = {DATA_W'(byte_align(r_s1_lfsr[23:16], DATA_W)),
                                         DATA_W'(byte_align(r_s1_lfsr[15:8],  DATA_W)),
                                         DATA_W'(byte_align(r_s1_lfsr[7:0],   DATA_W))};
                MODE_BLACK:   w_color = rgb_full(RGB_BLACK);
                default:      w_color = rgb_full(RGB_BLACK);
            endcase
        end
    end

    // Stage 2 output register; data holds on idle cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid       <= 1'b0;
            r_frame_start <= 1'b0;
            r_data        <= '0;
        end else begin
            r_valid       <= r_s1_vld;
            r_frame_start <= r_s1_fs;
            if (r_s1_vld) begin
                r_data <= w_color;
            end
        end
    end

    assign pix.valid       = r_valid;
    assign pix.frame_start = r_frame_start;
    assign pix.data        = r_data;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: each request pushes a model-derived expectation,
// a negedge monitor pops and compares whenever the DUT presents a pixel.
module tb_pattern_gen;

    localparam int          DW   = 8;
    localparam int          CW   = 12;
    localparam int          STEP = 4;
    localparam logic [23:0] SEED = 24'hACE1_5A;

    typedef struct {
        logic [23:0] data;
        logic        fs;
        int          h;
        int          v;
        int          cyc;
    } exp_t;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [2:0]    mode_in  = 3'd0;
    logic [23:0]   color_in = 24'h0;
    logic [CW-1:0] hres_in  = '0;
    logic [CW-1:0] vres_in  = '0;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic [2:0]  m_mode;
    int          m_hres, m_vres, m_scroll;
    logic [23:0] m_lfsr;
    logic [23:0] last_data;
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h000000, 24'h0000FF};

    pattern_gen_if #(.DATA_W(DW), .COORD_W(CW)) pix ();

    pattern_gen #(.DATA_W(DW), .COORD_W(CW), .GRID_SHIFT(5), .SCROLL_STEP(STEP), .LFSR_SEED(SEED)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_mode  (mode_in),
        .i_color (color_in),
        .i_h_res (hres_in),
        .i_v_res (vres_in),
        .pix     (pix)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] lfsr_next(input logic [23:0] s);
        logic lsb;
        lsb = s[0];
        s   = s >> 1;
        if (lsb) s = s ^ 24'hE10000;
        return s;
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                last_data = 24'h0;
            end else if (pix.valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: valid=1 data=%h with no outstanding request", pix.data);
                end else begin
                    e = sb.pop_front();
                    if (pix.data !== e.data) begin
                        errors++;
                        $display("FAIL px_data (%0d,%0d): got %h want %h", e.h, e.v, pix.data, e.data);
                    end
                    checks++;
                    if (pix.frame_start !== e.fs) begin
                        errors++;
                        $display("FAIL frame_start (%0d,%0d): got %b want %b", e.h, e.v, pix.frame_start, e.fs);
                    end
                    checks++;
                    if (cyc - e.cyc != 2) begin
                        errors++;
                        $display("FAIL latency (%0d,%0d): got %0d want 2", e.h, e.v, cyc - e.cyc);
                    end
                end
                last_data = pix.data;
            end else begin
                checks++;
                if (pix.data !== last_data || pix.frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_hold: data=%h fs=%b want data=%h fs=0", pix.data, pix.frame_start, last_data);
                end
            end
        end
    endtask

    task automatic send(input int h, input int v);
        exp_t        e;
        logic [23:0] val;
        logic [7:0]  g;
        int          bw, seg, d;
        if (h == 0 && v == 0) begin
            m_mode   = mode_in;
            m_hres   = int'(hres_in);
            m_vres   = int'(vres_in);
            m_scroll = m_scroll + STEP;
            if (m_scroll >= m_hres) m_scroll = m_scroll - m_hres;
        end
        val    = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        e.data = 24'h0;
        if (h >= m_hres || v >= m_vres) begin
            e.data = 24'h0;
        end else begin
            case (m_mode)
                3'd0: begin
                    bw = m_hres / 8;
                    if (bw == 0) e.data = 24'hFFFFFF;
                    else begin
                        seg = h / bw;
                        if (seg > 7) seg = 7;
                        e.data = bar_tab[seg];
                    end
                end
                3'd1: e.data = ((h % 32) == 0 || (v % 32) == 0) ? 24'hFF0000 : 24'h000000;
                3'd2: begin g = 8'(h); e.data = {g, g, g}; end
                3'd3: e.data = color_in;
                3'd4: e.data = (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
                3'd5: begin
                    d = (h - m_scroll + m_hres) % m_hres;
                    e.data = (d < 32) ? 24'hFFFFFF : 24'h000000;
                end
                3'd6: e.data = val;
                default: e.data = 24'h0;
            endcase
        end
        e.fs  = (h == 0 && v == 0);
        e.h   = h;
        e.v   = v;
        e.cyc = cyc;
        sb.push_back(e);
        pix.req        = 1'b1;
        pix.pixel_hpos = CW'(h);
        pix.pixel_vpos = CW'(v);
        @(posedge clk); #1;
        pix.req = 1'b0;
    endtask

    task automatic send_line(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) send(h, v);
    endtask

    task automatic idle(input int n);
        pix.req = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding want 0", sb.size());
        end
    endtask

    task automatic do_reset(input bit check_async);
        rstn    = 1'b0;
        pix.req = 1'b0;
        sb.delete();
        m_mode = 3'd0; m_hres = 0; m_vres = 0; m_scroll = 0; m_lfsr = SEED;
        if (check_async) begin
            #1;
            checks++;
            if (pix.valid !== 1'b0 || pix.data !== 24'h0 || pix.frame_start !== 1'b0) begin
                errors++;
                $display("FAIL async_reset: valid=%b data=%h fs=%b want 0", pix.valid, pix.data, pix.frame_start);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (pix.valid !== 1'b0 || pix.data !== 24'h0 || pix.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h fs=%b want 0", pix.valid, pix.data, pix.frame_start);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        hres_in = 12'd480; vres_in = 12'd272; mode_in = 3'd0;
        send(5, 3);
        send_line(0, 0, 479);
        send_line(1, 0, 479);
        drain();
    endtask

    task automatic test_bar_remainder();
        hres_in = 12'd485;
        send_line(0, 0, 484);
        drain();
        hres_in = 12'd5;
        send_line(0, 0, 6);
        drain();
    endtask

    task automatic test_mode_switch();
        hres_in = 12'd480; mode_in = 3'd0;
        send_line(0, 0, 479);
        mode_in = 3'd1;
        send_line(100, 0, 479);
        send_line(0, 0, 40);
        send_line(5, 0, 40);
        send_line(32, 0, 40);
        drain();
    endtask

    task automatic test_misc_modes();
        mode_in = 3'd2; send_line(0, 0, 3); send_line(3, 0, 299);
        mode_in = 3'd3; color_in = 24'h12_34_56; send_line(0, 0, 10); send(479, 271); send(480, 271);
        mode_in = 3'd4; send_line(0, 0, 70); send_line(40, 0, 70);
        mode_in = 3'd7; send_line(0, 0, 10);
        drain();
    endtask

    task automatic test_scroll();
        do_reset(1'b0);
        mode_in = 3'd5; hres_in = 12'd800; vres_in = 12'd600;
        send_line(0, 0, 40);
        for (int f = 2; f <= 199; f++) send(0, 0);
        send_line(0, 1, 40);
        send_line(1, 780, 799);
        send_line(0, 0, 40);
        drain();
    endtask

    task automatic test_noise_gaps();
        do_reset(1'b0);
        mode_in = 3'd6; hres_in = 12'd480; vres_in = 12'd272;
        for (int i = 0; i < 60; i++) begin
            send(i, 0);
            idle(1);
        end
        drain();
    endtask

    task automatic test_range_reset();
        mode_in = 3'd0; hres_in = 12'd480; vres_in = 12'd272;
        send_line(0, 0, 3);
        send(500, 0);
        send(10, 300);
        drain();
        send_line(1, 0, 20);
        do_reset(1'b1);
        send_line(0, 0, 70);
        drain();
    endtask

    initial begin
        pix.req        = 1'b0;
        pix.pixel_hpos = '0;
        pix.pixel_vpos = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_bar_remainder();
        test_mode_switch();
        test_misc_modes();
        test_scroll();
        test_noise_gaps();
        test_range_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
